// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite channel bundle (AR/R, AW/W/B) between a master and the slave memory model.
// W_STRB exists only when AXI_SLV_WSTRB_EN is defined.
interface axi_lite_slave_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              AR_VALID;
   logic [ADDR_W-1:0] AR_ADDR;
   logic              AR_READY;
   logic              R_VALID;
   logic [DATA_W-1:0] R_DATA;
   logic [1:0]        R_RESP;
   logic              R_READY;
   logic              AW_VALID;
   logic [ADDR_W-1:0] AW_ADDR;
   logic              AW_READY;
   logic              W_VALID;
   logic [DATA_W-1:0] W_DATA;
   logic              W_READY;
   logic              B_VALID;
   logic [1:0]        B_RESP;
   logic              B_READY;
`ifdef AXI_SLV_WSTRB_EN
   logic [DATA_W/8-1:0] W_STRB;

   modport slave (
      input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
      output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
   );
   modport master (
      output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
      input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
   );
`else
   modport slave (
      input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
   );
   modport master (
      output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
   );
`endif
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory: R_VALID RD_LAT edges after AR, B_VALID WR_LAT edges after AW+W; one txn per channel,
// responses held until READY. Optional byte strobes via macro AXI_SLV_WSTRB_EN.
module axi_lite_slave_mem #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH_LOG2 = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                RD_LAT     = 2,
   parameter int                WR_LAT     = 1
) (
   input logic              clk,
   input logic              rst_n,
   axi_lite_slave_mem_if.slave bus
);
   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);
   localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT - 1);

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a[ADDR_W-1:DEPTH_LOG2+2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2+2]) && (a[1:0] == 2'b00);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   // ---------------- read channel ----------------
   rd_state_t         rd_state, rd_state_nx;
   logic              ar_ready, ar_ready_nx, r_valid, r_valid_nx;
   logic [DATA_W-1:0] r_data, r_data_nx;
   logic [1:0]        r_resp, r_resp_nx;
   logic [3:0]        rd_cnt, rd_cnt_nx;
   logic [ADDR_W-1:0] rd_addr, rd_addr_nx;

   always_comb begin
      rd_state_nx = rd_state;
      ar_ready_nx = ar_ready;
      r_valid_nx  = r_valid;
      r_data_nx   = r_data;
      r_resp_nx   = r_resp;
      rd_cnt_nx   = rd_cnt;
      rd_addr_nx  = rd_addr;
      case (rd_state)
         RD_IDLE: begin
            ar_ready_nx = 1'b1;
            if (bus.AR_VALID && ar_ready) begin
               rd_addr_nx  = bus.AR_ADDR;
               ar_ready_nx = 1'b0;
               rd_cnt_nx   = RD_CNT_INIT;
               rd_state_nx = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_cnt == 4'd0) begin
               r_valid_nx  = 1'b1;
               r_resp_nx   = addr_ok(rd_addr) ? OKAY : SLVERR;
               r_data_nx   = addr_ok(rd_addr) ? mem[rd_addr[DEPTH_LOG2+1:2]] : '0;
               rd_state_nx = RD_RESP;
            end else begin
               rd_cnt_nx = rd_cnt - 4'd1;
            end
         end
         RD_RESP: begin
            if (bus.R_READY) begin
               r_valid_nx  = 1'b0;
               ar_ready_nx = 1'b1;
               rd_state_nx = RD_IDLE;
            end
         end
         default: rd_state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_resp   <= OKAY;
         rd_cnt   <= '0;
         rd_addr  <= '0;
      end else begin
         rd_state <= rd_state_nx;
         ar_ready <= ar_ready_nx;
         r_valid  <= r_valid_nx;
         r_data   <= r_data_nx;
         r_resp   <= r_resp_nx;
         rd_cnt   <= rd_cnt_nx;
         rd_addr  <= rd_addr_nx;
      end
   end

   // ---------------- write channel ----------------
   wr_state_t         wr_state, wr_state_nx;
   logic              aw_ready, aw_ready_nx, w_ready, w_ready_nx;
   logic              aw_got, aw_got_nx, w_got, w_got_nx;
   logic              b_valid, b_valid_nx, wr_en;
   logic [1:0]        b_resp, b_resp_nx;
   logic [3:0]        wr_cnt, wr_cnt_nx;
   logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
   logic [DATA_W-1:0] wr_data, wr_data_nx;
`ifdef AXI_SLV_WSTRB_EN
   logic [DATA_W/8-1:0] wr_strb, wr_strb_nx;
`endif

   always_comb begin
      wr_state_nx = wr_state;
      aw_ready_nx = aw_ready;
      w_ready_nx  = w_ready;
      aw_got_nx   = aw_got;
      w_got_nx    = w_got;
      b_valid_nx  = b_valid;
      b_resp_nx   = b_resp;
      wr_cnt_nx   = wr_cnt;
      wr_addr_nx  = wr_addr;
      wr_data_nx  = wr_data;
`ifdef AXI_SLV_WSTRB_EN
      wr_strb_nx  = wr_strb;
`endif
      wr_en       = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (bus.AW_VALID && aw_ready) begin
               aw_got_nx  = 1'b1;
               wr_addr_nx = bus.AW_ADDR;
            end
            if (bus.W_VALID && w_ready) begin
               w_got_nx   = 1'b1;
               wr_data_nx = bus.W_DATA;
`ifdef AXI_SLV_WSTRB_EN
               wr_strb_nx = bus.W_STRB;
`endif
            end
            aw_ready_nx = !aw_got_nx;
            w_ready_nx  = !w_got_nx;
            if (aw_got_nx && w_got_nx) begin
               aw_got_nx   = 1'b0;
               w_got_nx    = 1'b0;
               wr_cnt_nx   = WR_CNT_INIT;
               wr_state_nx = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (wr_cnt == 4'd0) begin
               wr_en       = addr_ok(wr_addr);
               b_valid_nx  = 1'b1;
               b_resp_nx   = addr_ok(wr_addr) ? OKAY : SLVERR;
               wr_state_nx = WR_RESP;
            end else begin
               wr_cnt_nx = wr_cnt - 4'd1;
            end
         end
         WR_RESP: begin
            if (bus.B_READY) begin
               b_valid_nx  = 1'b0;
               aw_ready_nx = 1'b1;
               w_ready_nx  = 1'b1;
               wr_state_nx = WR_IDLE;
            end
         end
         default: wr_state_nx = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state <= WR_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= OKAY;
         wr_cnt   <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
`ifdef AXI_SLV_WSTRB_EN
         wr_strb  <= '0;
`endif
      end else begin
         wr_state <= wr_state_nx;
         aw_ready <= aw_ready_nx;
         w_ready  <= w_ready_nx;
         aw_got   <= aw_got_nx;
         w_got    <= w_got_nx;
         b_valid  <= b_valid_nx;
         b_resp   <= b_resp_nx;
         wr_cnt   <= wr_cnt_nx;
         wr_addr  <= wr_addr_nx;
         wr_data  <= wr_data_nx;
`ifdef AXI_SLV_WSTRB_EN
         wr_strb  <= wr_strb_nx;
`endif
      end
   end

   // Read sampling above uses the pre-edge array, so a same-edge commit yields old data to the reader.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
`ifdef AXI_SLV_WSTRB_EN
         for (int b = 0; b < DATA_W/8; b++)
            if (wr_strb[b]) mem[wr_addr[DEPTH_LOG2+1:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
`else
         mem[wr_addr[DEPTH_LOG2+1:2]] <= wr_data;
`endif
      end
   end

   assign bus.AR_READY = ar_ready;
   assign bus.R_VALID  = r_valid;
   assign bus.R_DATA   = r_data;
   assign bus.R_RESP   = r_resp;
   assign bus.AW_READY = aw_ready;
   assign bus.W_READY  = w_ready;
   assign bus.B_VALID  = b_valid;
   assign bus.B_RESP   = b_resp;
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: vector table of writes/reads plus W-before-AW, backpressure and mid-read reset.
module tb_axi_lite_slave_mem;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   axi_lite_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_slave_mem #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .BASE_ADDR(32'h8000_0000),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Caller is at a negedge; returns response fields and edges from address handshake to VALID.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int n;
      bus.AW_VALID = 1'b1; bus.AW_ADDR = addr;
      bus.W_VALID  = 1'b1; bus.W_DATA  = data;
      n = 0;
      while (!(bus.AW_READY && bus.W_READY) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("aw_w_ready_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
      lat = 0;
      while (!bus.B_VALID && lat < 40) begin @(negedge clk); lat++; end
      resp = bus.B_RESP;
      bus.B_READY = 1'b1;
      @(negedge clk);
      bus.B_READY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
      int n;
      bus.AR_VALID = 1'b1; bus.AR_ADDR = addr;
      n = 0;
      while (!bus.AR_READY && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("ar_ready_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bus.AR_VALID = 1'b0;
      lat = 0;
      while (!bus.R_VALID && lat < 40) begin @(negedge clk); lat++; end
      data = bus.R_DATA;
      resp = bus.R_RESP;
      bus.R_READY = 1'b1;
      @(negedge clk);
      bus.R_READY = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;
      int          lat;
      int          n;
      logic        seen;

      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
      vecs[1]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
      vecs[2]  = '{1'b1, 32'h8000_0000, 32'hA5A5_0001, 2'b00};
      vecs[3]  = '{1'b0, 32'h4000_0000, 32'h0000_0000, 2'b10};
      vecs[4]  = '{1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 2'b10};
      vecs[5]  = '{1'b0, 32'h8000_0000, 32'hA5A5_0001, 2'b00};
      vecs[6]  = '{1'b1, 32'h8000_03FC, 32'hCAFE_F00D, 2'b00};
      vecs[7]  = '{1'b0, 32'h8000_03FC, 32'hCAFE_F00D, 2'b00};
      vecs[8]  = '{1'b0, 32'h8000_0400, 32'h0000_0000, 2'b10};
      vecs[9]  = '{1'b0, 32'h8000_0011, 32'h0000_0000, 2'b10};
      vecs[10] = '{1'b0, 32'h8000_0020, 32'h0000_0000, 2'b00};
      vecs[11] = '{1'b1, 32'h0000_0010, 32'h1111_1111, 2'b10};
      vecs[12] = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};

      rst_n = 1'b0;
      bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.R_READY = 1'b0;
      bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.W_VALID = 1'b0; bus.W_DATA = '0;
      bus.B_READY  = 1'b0;
`ifdef AXI_SLV_WSTRB_EN
      bus.W_STRB = 4'hF;
`endif
      repeat (3) @(negedge clk);
      chk("reset_flags", {25'd0, bus.AR_READY, bus.R_VALID, bus.R_RESP, bus.AW_READY, bus.W_READY,
                          bus.B_VALID, bus.B_RESP}, 32'd0);
      chk("reset_rdata", bus.R_DATA, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_readies", {29'd0, bus.AR_READY, bus.AW_READY, bus.W_READY}, 32'd7);

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, rs, lat);
            chk($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
            chk($sformatf("vec%0d_blat", i), lat, WR_LAT);
         end else begin
            do_read(vecs[i].addr, rd, rs, lat);
            chk($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
            chk($sformatf("vec%0d_rlat", i), lat, RD_LAT);
         end
      end

      // W captured first; later W_DATA changes while W_READY=0 must be ignored.
      bus.W_VALID = 1'b1; bus.W_DATA = 32'h1234_5678;
      @(negedge clk);
      bus.W_DATA = 32'hBAD0_BAD0;
      chk("wfirst_wready_low", {31'd0, bus.W_READY}, 32'd0);
      chk("wfirst_awready_high", {31'd0, bus.AW_READY}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("wfirst_no_early_b", {31'd0, bus.B_VALID}, 32'd0);
      bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h8000_0004;
      @(negedge clk);
      bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
      lat = 0;
      while (!bus.B_VALID && lat < 40) begin @(negedge clk); lat++; end
      chk("wfirst_blat", lat, WR_LAT);
      chk("wfirst_bresp", {30'd0, bus.B_RESP}, 32'd0);
      bus.B_READY = 1'b1;
      @(negedge clk);
      bus.B_READY = 1'b0;
      chk("wfirst_readies_back", {30'd0, bus.AW_READY, bus.W_READY}, 32'd3);
      do_read(32'h8000_0004, rd, rs, lat);
      chk("wfirst_rdata", rd, 32'h1234_5678);

      // R backpressure for 5 cycles with a competing AR held valid.
      bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h8000_0010;
      @(negedge clk);
      bus.AR_ADDR = 32'h8000_0000;
      n = 0;
      while (!bus.R_VALID && n < 40) begin @(negedge clk); n++; end
      chk("bp_rvalid_arrives", n, RD_LAT);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_c%0d_rvalid", c), {31'd0, bus.R_VALID}, 32'd1);
         chk($sformatf("bp_c%0d_rdata", c), bus.R_DATA, 32'hDEAD_BEEF);
         chk($sformatf("bp_c%0d_arready", c), {31'd0, bus.AR_READY}, 32'd0);
         @(negedge clk);
      end
      bus.R_READY = 1'b1;
      @(negedge clk);
      bus.R_READY = 1'b0;
      chk("bp_rvalid_drop", {31'd0, bus.R_VALID}, 32'd0);
      chk("bp_arready_back", {31'd0, bus.AR_READY}, 32'd1);
      @(negedge clk);
      bus.AR_VALID = 1'b0;
      n = 0;
      while (!bus.R_VALID && n < 40) begin @(negedge clk); n++; end
      chk("bp_second_lat", n, RD_LAT);
      chk("bp_second_rdata", bus.R_DATA, 32'hA5A5_0001);
      bus.R_READY = 1'b1;
      @(negedge clk);
      bus.R_READY = 1'b0;

      // Reset while the read is counting down: no response, memory cleared.
      bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h8000_0010;
      @(negedge clk);
      bus.AR_VALID = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         seen = seen | bus.R_VALID;
      end
      chk("rst_mid_no_rvalid", {31'd0, seen}, 32'd0);
      do_read(32'h8000_0010, rd, rs, lat);
      chk("rst_mid_cleared_data", rd, 32'd0);
      chk("rst_mid_cleared_resp", {30'd0, rs}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
